// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: parses byte packets arriving from a UART receiver and answers
// on the UART transmitter. Supports echo, 32-bit add (done in place) and
// 32-bit mul/div (delegated to an external unit with a request/result port).
//
// Handshake rule for rx, tx and op ports: a transfer happens only on a cycle
// where valid and ready are both high; once valid is raised it stays high
// with stable data until the transfer happens.
module uart_alu_ctrl #(
    parameter logic [7:0] OP_ECHO = 8'hEC,
    parameter logic [7:0] OP_ADD  = 8'hAD,
    parameter logic [7:0] OP_MUL  = 8'h88,
    parameter logic [7:0] OP_DIV  = 8'hD1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        op_sel_o,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    input  logic [31:0] res_i,
    input  logic        res_valid_i,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [3:0] {
        IDLE, HDR_RSV, LEN_LO, LEN_HI, ECHO, OPND,
        MULDIV_REQ, MULDIV_WAIT, SEND, DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] rem_q, rem_d;          // payload bytes still to be received
    logic [31:0] acc_q, acc_d;
    logic [23:0] opnd_q, opnd_d;        // first three bytes of the operand being assembled
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        first_q, first_d;      // next complete operand loads ACC
    logic        last_q, last_d;        // pending mul/div used the final operand
    logic [1:0]  snd_cnt_q, snd_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;  // doubles as the one-entry echo buffer
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        op_sel_q, op_sel_d;
    logic        op_valid_q, op_valid_d;
    logic        err_q, err_d;
    logic        rdy_en_q;              // holds rx_ready low until the first edge after reset

    logic        rx_ready;
    logic        rx_fire, tx_fire, op_fire;
    logic [15:0] len_w, payload_w;
    logic        is_alu_w;
    logic [31:0] word_w, sum_w;
    logic [1:0]  snd_next_w;
    logic        load_send;
    logic [31:0] send_val;

    // Header arithmetic and operand datapath helpers.
    always_comb begin
        len_w      = {rx_data_i, len_lo_q};
        payload_w  = (len_w < 16'd4) ? 16'd0 : (len_w - 16'd4);
        is_alu_w   = (opcode_q == OP_ADD) || (opcode_q == OP_MUL) || (opcode_q == OP_DIV);
        word_w     = {rx_data_i, opnd_q};
        sum_w      = acc_q + word_w;
        snd_next_w = snd_cnt_q + 2'd1;
    end

    // Receive readiness: header states always take a byte, payload states only
    // while bytes remain, echo only when its buffer is empty or emptying now.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            IDLE, HDR_RSV, LEN_LO, LEN_HI: rx_ready = 1'b1;
            OPND, DRAIN:                   rx_ready = (rem_q != 16'd0);
            ECHO:                          rx_ready = (rem_q != 16'd0) && (!tx_valid_q || tx_ready_i);
            default:                       rx_ready = 1'b0;
        endcase
        rx_ready = rx_ready && rdy_en_q;
    end

    assign rx_ready_o = rx_ready;
    assign rx_fire    = rx_valid_i && rx_ready;
    assign tx_fire    = tx_valid_q && tx_ready_i;
    assign op_fire    = op_valid_q && op_ready_i;

    // Next-state and datapath updates for the packet FSM.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        byte_cnt_d = byte_cnt_q;
        first_d    = first_q;
        last_d     = last_q;
        snd_cnt_d  = snd_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_sel_d   = op_sel_q;
        op_valid_d = op_valid_q;
        err_d      = 1'b0;
        load_send  = 1'b0;
        send_val   = acc_q;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    opcode_d = rx_data_i;
                    state_d  = HDR_RSV;
                end
            end
            HDR_RSV: begin
                if (rx_fire) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (rx_fire) begin
                    len_lo_d = rx_data_i;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_fire) begin
                    rem_d = payload_w;
                    if (opcode_q == OP_ECHO) begin
                        state_d = (payload_w == 16'd0) ? IDLE : ECHO;
                    end else if (is_alu_w && (payload_w[1:0] == 2'd0) && (payload_w >= 16'd8)) begin
                        state_d    = OPND;
                        byte_cnt_d = 2'd0;
                        first_d    = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ECHO: begin
                if (rx_fire) begin
                    tx_data_d  = rx_data_i;
                    tx_valid_d = 1'b1;
                    rem_d      = rem_q - 16'd1;
                end else if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    if (rem_q == 16'd0) state_d = IDLE;
                end
            end
            OPND: begin
                if (rx_fire) begin
                    rem_d      = rem_q - 16'd1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    opnd_d     = word_w[31:8];
                    if (byte_cnt_q == 2'd3) begin
                        if (first_q || (opcode_q == OP_ADD)) begin
                            acc_d   = first_q ? word_w : sum_w;
                            first_d = 1'b0;
                            if (rem_q == 16'd1) begin
                                load_send = 1'b1;
                                send_val  = acc_d;
                            end
                        end else begin
                            op_a_d     = acc_q;
                            op_b_d     = word_w;
                            op_sel_d   = (opcode_q == OP_DIV);
                            op_valid_d = 1'b1;
                            last_d     = (rem_q == 16'd1);
                            state_d    = MULDIV_REQ;
                        end
                    end
                end
            end
            MULDIV_REQ: begin
                if (op_fire) begin
                    op_valid_d = 1'b0;
                    state_d    = MULDIV_WAIT;
                end
            end
            MULDIV_WAIT: begin
                if (res_valid_i) begin
                    acc_d = res_i;
                    if (last_q) begin
                        load_send = 1'b1;
                        send_val  = res_i;
                    end else begin
                        state_d = OPND;
                    end
                end
            end
            SEND: begin
                if (tx_fire) begin
                    if (snd_cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        snd_cnt_d = snd_next_w;
                        tx_data_d = acc_q[{snd_next_w, 3'b000} +: 8];
                    end
                end
            end
            DRAIN: begin
                if (rem_q == 16'd0) begin
                    state_d = IDLE;
                end else if (rx_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result ready: present byte 0 right away, LSB first.
        if (load_send) begin
            acc_d      = send_val;
            tx_data_d  = send_val[7:0];
            tx_valid_d = 1'b1;
            snd_cnt_d  = 2'd0;
            state_d    = SEND;
        end
    end

    // State and registered outputs; reset returns everything to idle zeros.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            opcode_q   <= 8'd0;
            len_lo_q   <= 8'd0;
            rem_q      <= 16'd0;
            acc_q      <= 32'd0;
            opnd_q     <= 24'd0;
            byte_cnt_q <= 2'd0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            snd_cnt_q  <= 2'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            op_sel_q   <= 1'b0;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            byte_cnt_q <= byte_cnt_d;
            first_q    <= first_d;
            last_q     <= last_d;
            snd_cnt_q  <= snd_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_sel_q   <= op_sel_d;
            op_valid_q <= op_valid_d;
            err_q      <= err_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign op_a_o     = op_a_q;
    assign op_b_o     = op_b_q;
    assign op_sel_o   = op_sel_q;
    assign op_valid_o = op_valid_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: directed packets, then random packets, each
// compared against a packet-level reference model.
module tb_uart_alu_ctrl;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] op_a_o, op_b_o;
    logic        op_sel_o, op_valid_o, op_ready_i;
    logic [31:0] res_i;
    logic        res_valid_i;
    logic        busy_o, err_o;

    uart_alu_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .op_a_o(op_a_o), .op_b_o(op_b_o), .op_sel_o(op_sel_o),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .res_i(res_i), .res_valid_i(res_valid_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    logic [7:0]  pkt_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  tx_got_q[$];
    logic [64:0] req_exp_q[$];
    logic [64:0] req_got_q[$];
    int          err_cnt = 0;
    int          exp_err = 0;

    int tx_hold = 0;
    bit tx_rand = 1'b0;
    int unit_stall = 0;
    int unit_delay = 1;
    bit unit_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // External mul/div unit behaviour; division by zero returns a marker.
    function automatic logic [31:0] unit_fn(input logic sel, input logic [31:0] a, input logic [31:0] b);
        if (!sel) return a * b;
        if (b == 32'd0) return 32'hDEAD_BEEF;
        return a / b;
    endfunction

    // ---------------- TX ready driver (changes just after posedge) ----------------
    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            if (tx_hold > 0) begin
                tx_ready_i = 1'b0;
                tx_hold--;
            end else if (tx_rand) begin
                tx_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                tx_ready_i = 1'b1;
            end
        end
    end

    // ---------------- TX monitor / protocol checks ----------------
    logic       hold_prev = 1'b0;
    logic [7:0] data_prev = 8'd0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("tx_valid_held", 32'(tx_valid_o), 32'd1);
                check("tx_data_held", 32'(tx_data_o), 32'(data_prev));
            end
            if (tx_valid_o && !tx_ready_i)
                check("rx_ready_low_buffer_full", 32'(rx_ready_o), 32'd0);
            if (tx_valid_o && tx_ready_i) tx_got_q.push_back(tx_data_o);
            if (err_o) err_cnt++;
            hold_prev = tx_valid_o && !tx_ready_i;
            data_prev = tx_data_o;
        end
    end

    // ---------------- external mul/div unit ----------------
    initial begin
        logic [31:0] a, b;
        logic        s;
        int          stall, delay;
        op_ready_i  = 1'b0;
        res_valid_i = 1'b0;
        res_i       = 32'd0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && op_valid_o) begin
                a = op_a_o; b = op_b_o; s = op_sel_o;
                stall = unit_rand ? $urandom_range(0, 6) : unit_stall;
                delay = unit_rand ? $urandom_range(0, 12) : unit_delay;
                for (int i = 0; i < stall; i++) begin
                    @(posedge clk_i); #1;
                    res_valid_i = (i == 0);          // stray result while a request is pending
                    res_i       = 32'h5A5A_5A5A;
                    @(negedge clk_i);
                    check("op_valid_stall", 32'(op_valid_o), 32'd1);
                    check("op_a_stall", op_a_o, a);
                    check("op_b_stall", op_b_o, b);
                    check("op_sel_stall", 32'(op_sel_o), 32'(s));
                end
                @(posedge clk_i); #1;
                res_valid_i = 1'b0;
                op_ready_i  = 1'b1;
                @(negedge clk_i);
                check("op_valid_at_accept", 32'(op_valid_o), 32'd1);
                @(posedge clk_i); #1;
                op_ready_i = 1'b0;
                req_got_q.push_back({s, a, b});
                for (int i = 0; i < delay; i++) begin
                    @(posedge clk_i); #1;
                end
                res_valid_i = 1'b1;
                res_i       = unit_fn(s, a, b);
                @(posedge clk_i); #1;
                res_valid_i = 1'b0;
            end
        end
    end

    // ---------------- reference model (packet level) ----------------
    task automatic model_packet();
        logic [7:0]  op;
        int          len, pay;
        logic [31:0] acc, w;
        exp_q.delete();
        req_exp_q.delete();
        exp_err = 0;
        acc = 32'd0;
        op  = pkt_q[0];
        len = int'(pkt_q[2]) + 256 * int'(pkt_q[3]);
        pay = (len < 4) ? 0 : len - 4;
        if (op == OP_ECHO) begin
            for (int i = 0; i < pay; i++) exp_q.push_back(pkt_q[4 + i]);
        end else if ((op == OP_ADD || op == OP_MUL || op == OP_DIV) && (pay % 4 == 0) && (pay >= 8)) begin
            for (int k = 0; k < pay / 4; k++) begin
                w = {pkt_q[4 + 4*k + 3], pkt_q[4 + 4*k + 2], pkt_q[4 + 4*k + 1], pkt_q[4 + 4*k]};
                if (k == 0) acc = w;
                else if (op == OP_ADD) acc = acc + w;
                else begin
                    req_exp_q.push_back({op == OP_DIV, acc, w});
                    acc = unit_fn(op == OP_DIV, acc, w);
                end
            end
            for (int i = 0; i < 4; i++) exp_q.push_back(acc[8*i +: 8]);
        end else begin
            exp_err = 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic begin_pkt(input logic [7:0] op, input int len);
        pkt_q.delete();
        pkt_q.push_back(op);
        pkt_q.push_back(8'($urandom));
        pkt_q.push_back(8'(len));
        pkt_q.push_back(8'(len >> 8));
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) pkt_q.push_back(w[8*i +: 8]);
    endtask

    task automatic add_bytes(input int n);
        for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check("rx_accept_timeout", 32'(n >= 2000), 32'd0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || tx_valid_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_timeout", 32'(n >= 3000), 32'd0);
    endtask

    task automatic run_packet(input string tag, input int hold_at);
        int n;
        model_packet();
        tx_got_q.delete();
        req_got_q.delete();
        err_cnt = 0;
        foreach (pkt_q[i]) begin
            if (i == hold_at) tx_hold = 20;
            send_byte(pkt_q[i]);
        end
        wait_idle();
        repeat (3) @(negedge clk_i);
        check({tag, "_tx_count"}, 32'(tx_got_q.size()), 32'(exp_q.size()));
        n = (tx_got_q.size() < exp_q.size()) ? tx_got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_tx_byte"}, 32'(tx_got_q[i]), 32'(exp_q[i]));
        check({tag, "_req_count"}, 32'(req_got_q.size()), 32'(req_exp_q.size()));
        n = (req_got_q.size() < req_exp_q.size()) ? req_got_q.size() : req_exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_req_a"}, req_got_q[i][63:32], req_exp_q[i][63:32]);
            check({tag, "_req_b"}, req_got_q[i][31:0], req_exp_q[i][31:0]);
            check({tag, "_req_sel"}, 32'(req_got_q[i][64]), 32'(req_exp_q[i][64]));
        end
        check({tag, "_err_pulses"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready_o), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
        check({tag, "_op_valid"}, 32'(op_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
        check({tag, "_op_a"}, op_a_o, 32'd0);
        check({tag, "_op_b"}, op_b_o, 32'd0);
        check({tag, "_op_sel"}, 32'(op_sel_o), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed then random sequence ----------------
    initial begin
        int          kind, pay, len;
        logic [7:0]  op;
        logic [31:0] w;

        rst_ni     = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'd0;
        repeat (3) @(negedge clk_i);
        check_reset_values("reset");
        rst_ni = 1'b1;
        check("rx_ready_at_release", 32'(rx_ready_o), 32'd0);
        @(negedge clk_i);
        check("rx_ready_after_release", 32'(rx_ready_o), 32'd1);

        // echo EC 00 08 00 42 69 42 69
        pkt_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69};
        run_packet("echo", -1);

        // add 1+2+3
        begin_pkt(OP_ADD, 16); add_word(32'd1); add_word(32'd2); add_word(32'd3);
        run_packet("add123", -1);

        // add with wrap
        begin_pkt(OP_ADD, 12); add_word(32'hFFFF_FFFF); add_word(32'd2);
        run_packet("add_wrap", -1);

        // mul 3*7*2 with stalled request and late result
        unit_stall = 5; unit_delay = 10;
        begin_pkt(OP_MUL, 16); add_word(32'd3); add_word(32'd7); add_word(32'd2);
        run_packet("mul", -1);
        unit_stall = 0; unit_delay = 1;

        // div 100/7 then divide by zero
        begin_pkt(OP_DIV, 16); add_word(32'd100); add_word(32'd7); add_word(32'd0);
        run_packet("div", -1);

        // bad opcode, 3 payload bytes drained
        begin_pkt(8'h55, 7); add_bytes(3);
        run_packet("bad_op", -1);

        // add with payload not a multiple of 4
        begin_pkt(OP_ADD, 10); add_bytes(6);
        run_packet("add_len10", -1);

        // LEN below header size: echo with nothing, and a bad opcode
        begin_pkt(OP_ECHO, 2);
        run_packet("echo_len2", -1);
        begin_pkt(8'h01, 0);
        run_packet("bad_len0", -1);

        // echo with 20 cycles of TX backpressure mid-packet
        begin_pkt(OP_ECHO, 12); add_bytes(8);
        run_packet("echo_bp", 6);

        // reset after LEN_LO of an add packet
        send_byte(OP_ADD);
        send_byte(8'h00);
        send_byte(8'h10);
        rst_ni = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rx_ready_after_midreset", 32'(rx_ready_o), 32'd1);
        begin_pkt(OP_ECHO, 9); add_bytes(5);
        run_packet("echo_after_reset", -1);

        // random packets with random backpressure on both sides
        tx_rand = 1'b1;
        unit_rand = 1'b1;
        for (int r = 0; r < 24; r++) begin
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                op  = OP_ECHO;
                pay = $urandom_range(0, 10);
            end else if (kind == 4) begin
                do op = 8'($urandom_range(0, 255));
                while (op == OP_ECHO || op == OP_ADD || op == OP_MUL || op == OP_DIV);
                pay = $urandom_range(0, 6);
            end else begin
                op  = (kind == 1) ? OP_ADD : (kind == 2) ? OP_MUL : OP_DIV;
                pay = ($urandom_range(0, 4) != 0) ? 4 * $urandom_range(2, 4) : $urandom_range(0, 11);
            end
            len = pay + 4;
            if (pay == 0 && $urandom_range(0, 1) == 1) len = $urandom_range(0, 4);
            begin_pkt(op, len);
            if (kind >= 1 && kind <= 3) begin
                for (int k = 0; k < pay / 4; k++) begin
                    w = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    add_word(w);
                end
                add_bytes(pay % 4);
            end else begin
                add_bytes(pay);
            end
            run_packet("random", -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 SHALL have parameter OP_ECHO, 8'hEC, echo opcode.
REQ-002 SHALL have parameter OP_ADD, 8'hAD, 32-bit sum opcode.
REQ-003 SHALL have parameter OP_MUL, 8'h88, 32-bit product opcode (external unit).
REQ-004 SHALL have parameter OP_DIV, 8'hD1, unsigned 32-bit quotient opcode (external unit).
REQ-005 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports rx_data_i input 8, rx_valid_i input 1, rx_ready_o output 1  byte stream from UART RX.
REQ-008 SHALL have ports tx_data_o output 8, tx_valid_o output 1, tx_ready_i input 1  byte stream to UART TX.
REQ-009 SHALL have ports op_a_o output 32, op_b_o output 32, op_sel_o output 1 (0=mul, 1=div), op_valid_o output 1, op_ready_i input 1  request to external mul/div unit.
REQ-010 SHALL have ports res_i input 32, res_valid_i input 1  single-cycle result return from external unit.
REQ-011 SHALL have ports busy_o output 1 (state not IDLE) and err_o output 1 (one-cycle error pulse).

Function
REQ-012 Transfers SHALL occur only on cycles where valid and ready are both high; tx_valid_o and op_valid_o, once high, SHALL hold with stable data until accepted.
REQ-013 Packet SHALL be: opcode, reserved byte (ignored), LEN low, LEN high; LEN = total bytes including 4-byte header; payload = LEN-4; operands 32-bit little-endian.
REQ-014 FSM states SHALL be: IDLE, HDR_RSV, LEN_LO, LEN_HI, ECHO, OPND, MULDIV_REQ, MULDIV_WAIT, SEND, DRAIN.
REQ-015 IDLE->HDR_RSV->LEN_LO->LEN_HI SHALL advance one state per accepted byte, storing opcode and LEN.
REQ-016 After LEN_HI: OP_ECHO->ECHO; OP_ADD/MUL/DIV with payload a multiple of 4 and >=8 -> OPND; anything else -> DRAIN with err_o pulsed the following cycle.
REQ-017 DRAIN SHALL accept and discard the remaining payload bytes, produce no TX output, then go to IDLE; LEN<4 SHALL be treated as payload 0.
REQ-018 ECHO SHALL forward each payload byte unchanged through a one-entry buffer: rx_ready_o high only while the buffer is empty or draining this cycle; IDLE once the last byte is accepted by TX; payload 0 -> IDLE immediately.
REQ-019 OPND SHALL assemble 4 bytes; the first operand SHALL load accumulator ACC.
REQ-020 OP_ADD: each later operand SHALL set ACC = ACC + operand mod 2^32, within OPND with no extra cycle.
REQ-021 OP_MUL/OP_DIV: each later operand SHALL go to MULDIV_REQ with op_a_o=ACC, op_b_o=operand, op_valid_o=1; on handshake -> MULDIV_WAIT; res_valid_i loads ACC=res_i and returns to OPND, or to SEND after the last operand.
REQ-022 rx_ready_o SHALL be low in MULDIV_REQ, MULDIV_WAIT and SEND; res_valid_i outside MULDIV_WAIT SHALL be ignored.
REQ-023 After the last operand, SEND SHALL emit ACC as 4 bytes LSB first, then go to IDLE; the result of a division by zero SHALL be whatever res_i returns.
REQ-024 Bytes of the next packet SHALL not be accepted before the previous response has fully transmitted.
REQ-025 LEN SHALL be a 16-bit unsigned value; the payload counter SHALL not wrap (max 65531 payload bytes).

Reset
REQ-026 On rst_ni low, state SHALL be IDLE, counters/ACC/buffer 0; rx_ready_o=0, tx_valid_o=0, op_valid_o=0, busy_o=0, err_o=0, tx_data_o=0, op_a_o=0, op_b_o=0, op_sel_o=0.
REQ-027 rx_ready_o SHALL be 1 from the first clock edge after reset release while in IDLE.
REQ-028 Reset mid-packet SHALL abort all activity; the first byte after release SHALL be parsed as an opcode.

Verification
REQ-029 Echo: EC 00 08 00 42 69 42 69 -> TX 42 69 42 69, then busy_o=0.
REQ-030 Add: AD 00 10 00 + operands 1, 2, 3 -> TX 06 00 00 00; FFFFFFFF + 00000002 -> TX 01 00 00 00.
REQ-031 Mul with op_ready_i stalled 5 cycles and res_valid_i 10 cycles late: operands 3, 7, 2 -> two requests (3*7, 21*2), TX 2A 00 00 00; op_a/op_b stable during the stall.
REQ-032 Bad opcode 55 with LEN=7 -> 3 payload bytes discarded, err_o one pulse, no TX; AD with LEN=10 -> err_o, 6 bytes drained.
REQ-033 TX backpressure: tx_ready_i low for 20 cycles mid-echo -> no byte lost or duplicated, rx_ready_o low while the buffer is full.
REQ-034 rst_ni asserted after LEN_LO of an add packet -> all outputs at reset values; a following full echo packet completes correctly.
